// File: rtl/wb_arbiter_n.sv
// N-master to 1-slave Wishbone arbiter (round-robin or fixed priority); grant held for the whole cycle.
// Define WB_ARB_TIMEOUT_EN to add a bus watchdog that errors out a silent slave after TIMEOUT_CYCLES.
module wb_arbiter_n #(
    parameter int NUM_MASTERS    = 3,
    parameter int AW             = 24,
    parameter int DW             = 16,
    parameter int SW             = 2,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_MASTERS-1:0]    m_wb_cyc,
    input  logic [NUM_MASTERS-1:0]    m_wb_stb,
    input  logic [NUM_MASTERS-1:0]    m_wb_we,
    input  logic [NUM_MASTERS*AW-1:0] m_wb_adr,
    input  logic [NUM_MASTERS*DW-1:0] m_wb_o_dat,
    input  logic [NUM_MASTERS*SW-1:0] m_wb_sel,
    input  logic [NUM_MASTERS-1:0]    m_wb_4_burst,
    input  logic [NUM_MASTERS-1:0]    m_wb_8_burst,
    output logic [DW-1:0]             m_wb_i_dat,
    output logic [NUM_MASTERS-1:0]    m_wb_ack,
    output logic [NUM_MASTERS-1:0]    m_wb_err,
    output logic                      s_wb_cyc,
    output logic                      s_wb_stb,
    output logic                      s_wb_we,
    output logic [AW-1:0]             s_wb_adr,
    output logic [DW-1:0]             s_wb_o_dat,
    output logic [SW-1:0]             s_wb_sel,
    output logic                      s_wb_4_burst,
    output logic                      s_wb_8_burst,
    input  logic [DW-1:0]             s_wb_i_dat,
    input  logic                      s_wb_ack,
    input  logic                      s_wb_err,
    output logic [NUM_MASTERS-1:0]    o_grant
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("wb_arbiter_n: parameter out of range");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state, state_next;
    logic [NUM_MASTERS-1:0] grant, grant_next, req;
    logic [IW-1:0]          ptr, ptr_next, win, cand;
    logic                   found, timeout;
    logic                   g_cyc, g_stb, g_we, g_b4, g_b8;
    logic [AW-1:0]          g_adr;
    logic [DW-1:0]          g_dat;
    logic [SW-1:0]          g_sel;
    int unsigned            idx;

    // Granted master's bus; all zero while grant is empty.
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_b4  = 1'b0;
        g_b8  = 1'b0;
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (grant[k]) begin
                g_cyc = m_wb_cyc[k];
                g_stb = m_wb_stb[k];
                g_we  = m_wb_we[k];
                g_b4  = m_wb_4_burst[k];
                g_b8  = m_wb_8_burst[k];
                g_adr = m_wb_adr[k*AW +: AW];
                g_dat = m_wb_o_dat[k*DW +: DW];
                g_sel = m_wb_sel[k*SW +: SW];
            end
        end
    end

    // Search order starts at ptr (next index after the last winner) in round-robin mode.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            idx  = (ARB_MODE == 0) ? (int'(ptr) + i) % NUM_MASTERS : i;
            cand = IW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_next = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win;
                    state_next = BUSY;
                    if (ARB_MODE == 0) begin
                        if (int'(win) == NUM_MASTERS - 1) ptr_next = '0;
                        else                              ptr_next = win + 1'b1;
                    end
                end
            end
            BUSY: begin
                if (!g_cyc || timeout) begin
                    grant_next = '0;
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            ptr   <= ptr_next;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0]            to_cnt, to_cnt_next;
    logic [NUM_MASTERS-1:0] blocked, blocked_next;

    // A timed-out master stays masked until it drops cyc once.
    always_comb begin
        to_cnt_next = '0;
        timeout     = 1'b0;
        if (state == BUSY && g_stb && !s_wb_ack && !s_wb_err) begin
            if (to_cnt == 16'(TIMEOUT_CYCLES)) timeout = 1'b1;
            else                               to_cnt_next = to_cnt + 16'd1;
        end
        blocked_next = (blocked & m_wb_cyc) | (timeout ? grant : '0);
    end

    assign req = m_wb_cyc & ~blocked;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            to_cnt  <= '0;
            blocked <= '0;
        end else begin
            to_cnt  <= to_cnt_next;
            blocked <= blocked_next;
        end
    end
`else
    assign timeout = 1'b0;
    assign req     = m_wb_cyc;
`endif

    assign s_wb_cyc     = g_cyc & ~timeout;
    assign s_wb_stb     = g_stb & ~timeout;
    assign s_wb_we      = g_we;
    assign s_wb_adr     = g_adr;
    assign s_wb_o_dat   = g_dat;
    assign s_wb_sel     = g_sel;
    assign s_wb_4_burst = g_b4;
    assign s_wb_8_burst = g_b8;
    assign m_wb_i_dat   = s_wb_i_dat;
    assign m_wb_ack     = grant & {NUM_MASTERS{s_wb_ack & ~s_wb_err & ~timeout}};
    assign m_wb_err     = grant & {NUM_MASTERS{s_wb_err | timeout}};
    assign o_grant      = grant;

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Directed bench for wb_arbiter_n: one round-robin and one fixed-priority instance on shared stimulus.
// Timeout scenario runs when WB_ARB_TIMEOUT_EN is defined, otherwise the hang behaviour is checked.
module tb_wb_arbiter_n;
    localparam int N  = 3;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int SW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    m_cyc, m_stb, m_we, m_b4, m_b8;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N*SW-1:0] m_sel;
    logic [DW-1:0]   s_dat;
    logic            s_ack, s_err;

    logic [DW-1:0] rr_i_dat, fp_i_dat, rr_dat, fp_dat;
    logic [N-1:0]  rr_ack, rr_err, rr_grant, fp_ack, fp_err, fp_grant;
    logic          rr_cyc, rr_stb, rr_we, rr_b4, rr_b8;
    logic          fp_cyc, fp_stb, fp_we, fp_b4, fp_b8;
    logic [AW-1:0] rr_adr, fp_adr;
    logic [SW-1:0] rr_sel, fp_sel;

    wb_arbiter_n #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .SW(SW), .ARB_MODE(0), .TIMEOUT_CYCLES(16)) u_rr (
        .i_clk(clk), .i_rst_n(rst_n),
        .m_wb_cyc(m_cyc), .m_wb_stb(m_stb), .m_wb_we(m_we), .m_wb_adr(m_adr),
        .m_wb_o_dat(m_dat), .m_wb_sel(m_sel), .m_wb_4_burst(m_b4), .m_wb_8_burst(m_b8),
        .m_wb_i_dat(rr_i_dat), .m_wb_ack(rr_ack), .m_wb_err(rr_err),
        .s_wb_cyc(rr_cyc), .s_wb_stb(rr_stb), .s_wb_we(rr_we), .s_wb_adr(rr_adr),
        .s_wb_o_dat(rr_dat), .s_wb_sel(rr_sel), .s_wb_4_burst(rr_b4), .s_wb_8_burst(rr_b8),
        .s_wb_i_dat(s_dat), .s_wb_ack(s_ack), .s_wb_err(s_err), .o_grant(rr_grant)
    );

    wb_arbiter_n #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .SW(SW), .ARB_MODE(1), .TIMEOUT_CYCLES(16)) u_fp (
        .i_clk(clk), .i_rst_n(rst_n),
        .m_wb_cyc(m_cyc), .m_wb_stb(m_stb), .m_wb_we(m_we), .m_wb_adr(m_adr),
        .m_wb_o_dat(m_dat), .m_wb_sel(m_sel), .m_wb_4_burst(m_b4), .m_wb_8_burst(m_b8),
        .m_wb_i_dat(fp_i_dat), .m_wb_ack(fp_ack), .m_wb_err(fp_err),
        .s_wb_cyc(fp_cyc), .s_wb_stb(fp_stb), .s_wb_we(fp_we), .s_wb_adr(fp_adr),
        .s_wb_o_dat(fp_dat), .s_wb_sel(fp_sel), .s_wb_4_burst(fp_b4), .s_wb_8_burst(fp_b8),
        .s_wb_i_dat(s_dat), .s_wb_ack(s_ack), .s_wb_err(s_err), .o_grant(fp_grant)
    );

    int checks = 0;
    int errors = 0;
    int ack_cnt;
    logic [N-1:0] exp_g;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change at posedge+1; outputs are sampled at the following negedge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_req(input logic [N-1:0] r);
        m_cyc = r;
        m_stb = r;
    endtask

    task automatic do_reset();
        set_req('0);
        s_ack = 1'b0;
        s_err = 1'b0;
        m_b4  = '0;
        m_b8  = '0;
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        m_adr = {24'h222222, 24'h000100, 24'h111111};
        m_dat = {16'h2222, 16'h1111, 16'h0000};
        m_sel = {2'b11, 2'b01, 2'b10};
        m_we  = 3'b101;
        m_b4  = '0;
        m_b8  = '0;
        s_dat = '0;
        s_err = 1'b0;

        // Requests and acks during reset are ignored.
        set_req(3'b111);
        s_ack = 1'b1;
        next_cycle();
        sample();
        check_eq("rst_grant", rr_grant, 3'b000);
        check_eq("rst_cyc", {rr_cyc, rr_stb}, 2'b00);
        check_eq("rst_ack", rr_ack, 3'b000);
        check_eq("rst_adr", rr_adr, 24'h000000);

        // Single read from m1.
        do_reset();
        set_req(3'b010);
        sample();
        check_eq("t1_latency", rr_cyc, 1'b0);
        next_cycle();
        sample();
        check_eq("t1_cyc", rr_cyc, 1'b1);
        check_eq("t1_adr", rr_adr, 24'h000100);
        check_eq("t1_grant", rr_grant, 3'b010);
        check_eq("t1_we", rr_we, 1'b0);
        check_eq("t1_sel", rr_sel, 2'b01);
        check_eq("t1_wdat", rr_dat, 16'h1111);
        next_cycle();
        s_ack = 1'b1;
        s_dat = 16'hBEEF;
        sample();
        check_eq("t1_ack", rr_ack, 3'b010);
        check_eq("t1_rdata", rr_i_dat, 16'hBEEF);
        next_cycle();
        s_ack = 1'b0;
        set_req(3'b000);
        sample();
        check_eq("t1_cyc_drop", rr_cyc, 1'b0);
        next_cycle();
        sample();
        check_eq("t1_idle", rr_grant, 3'b000);

        // Round-robin fairness with all masters requesting.
        do_reset();
        set_req(3'b111);
        next_cycle();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++) begin
                exp_g = 3'b001 << k;
                s_ack = 1'b1;
                sample();
                check_eq("t2_grant", rr_grant, exp_g);
                check_eq("t2_ack", rr_ack, exp_g);
                next_cycle();
                s_ack = 1'b0;
                m_cyc[k] = 1'b0;
                m_stb[k] = 1'b0;
                next_cycle();
                set_req(3'b111);
                sample();
                check_eq("t2_dead", rr_grant, 3'b000);
                next_cycle();
            end
        end

        // Fixed priority: m0 beats m2 and holds until it drops cyc.
        do_reset();
        set_req(3'b101);
        next_cycle();
        sample();
        check_eq("t3_grant", fp_grant, 3'b001);
        next_cycle();
        s_ack = 1'b1;
        sample();
        check_eq("t3_ack", fp_ack, 3'b001);
        check_eq("t3_adr", fp_adr, 24'h111111);
        check_eq("t3_we", fp_we, 1'b1);
        next_cycle();
        s_ack = 1'b0;
        sample();
        check_eq("t3_hold", fp_grant, 3'b001);
        next_cycle();
        set_req(3'b100);
        sample();
        check_eq("t3_drop_grant", fp_grant, 3'b001);
        check_eq("t3_drop_cyc", fp_cyc, 1'b0);
        next_cycle();
        sample();
        check_eq("t3_dead", fp_grant, 3'b000);
        next_cycle();
        sample();
        check_eq("t3_m2_grant", fp_grant, 3'b100);
        check_eq("t3_m2_adr", fp_adr, 24'h222222);

        // m2 4-beat burst, m0 arrives mid-burst and waits.
        do_reset();
        m_b4 = 3'b100;
        m_b8 = 3'b001;
        set_req(3'b100);
        next_cycle();
        ack_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            if (b == 1) set_req(3'b101);
            s_ack = 1'b1;
            sample();
            check_eq("t4_grant", rr_grant, 3'b100);
            check_eq("t4_ack", rr_ack, 3'b100);
            check_eq("t4_burst", {rr_b4, rr_b8}, 2'b10);
            ack_cnt += int'(rr_ack[2]);
            next_cycle();
        end
        check_eq("t4_ack_count", ack_cnt, 4);
        s_ack = 1'b0;
        set_req(3'b001);
        sample();
        check_eq("t4_end_cyc", rr_cyc, 1'b0);
        next_cycle();
        sample();
        check_eq("t4_dead", rr_grant, 3'b000);
        next_cycle();
        sample();
        check_eq("t4_m0_grant", rr_grant, 3'b001);
        check_eq("t4_m0_burst", {rr_b4, rr_b8}, 2'b01);
        check_eq("t4_m0_adr", rr_adr, 24'h111111);

        // Error and ack in the same cycle: error wins.
        do_reset();
        set_req(3'b010);
        next_cycle();
        s_ack = 1'b1;
        s_err = 1'b1;
        sample();
        check_eq("t5_err", rr_err, 3'b010);
        check_eq("t5_ack_suppressed", rr_ack, 3'b000);
        next_cycle();
        s_err = 1'b0;
        sample();
        check_eq("t5_ack_only", rr_ack, 3'b010);
        check_eq("t5_err_clear", rr_err, 3'b000);
        next_cycle();
        s_ack = 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
        // Silent slave: error pulse once the counter reaches 16.
        do_reset();
        set_req(3'b010);
        next_cycle();
        for (int c = 0; c < 16; c++) begin
            sample();
            check_eq("t6_no_early_err", rr_err, 3'b000);
            next_cycle();
        end
        sample();
        check_eq("t6_err_pulse", rr_err, 3'b010);
        check_eq("t6_cyc_forced", rr_cyc, 1'b0);
        next_cycle();
        sample();
        check_eq("t6_idle", rr_grant, 3'b000);
        check_eq("t6_err_once", rr_err, 3'b000);
        next_cycle();
        sample();
        check_eq("t6_blocked", rr_grant, 3'b000);
        next_cycle();
        set_req(3'b000);
        next_cycle();
        set_req(3'b010);
        next_cycle();
        sample();
        check_eq("t6_regrant", rr_grant, 3'b010);
`else
        // No watchdog: a silent slave keeps the grant indefinitely.
        do_reset();
        set_req(3'b010);
        next_cycle();
        repeat (40) next_cycle();
        sample();
        check_eq("t6_hang_grant", rr_grant, 3'b010);
        check_eq("t6_hang_err", rr_err, 3'b000);
        check_eq("t6_hang_cyc", rr_cyc, 1'b1);
`endif

        // Asynchronous reset in the middle of a transfer.
        do_reset();
        set_req(3'b001);
        next_cycle();
        sample();
        check_eq("t7_busy", rr_cyc, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t7_rst_cyc", {rr_cyc, rr_stb}, 2'b00);
        check_eq("t7_rst_grant", rr_grant, 3'b000);
        next_cycle();
        set_req(3'b000);
        rst_n = 1'b1;
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
